// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin CPU/debug access to a byte-wide data memory,
// each 32-bit word moved as four big-endian byte beats.
module dmem_port_arbiter #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_ack,
    output logic [31:0]   c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          grant_id
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    beat_q, beat_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [23:0]   shift_q, shift_d;
    logic [31:0]   c_rdata_q, c_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          win, xfer, last;
    logic [31:0]   rword;

    always_comb begin
        // on a tie the port that did not hold the last grant wins
        win       = (c_req && d_req) ? ~grant_q : d_req;
        xfer      = state_q == XFER;
        last      = xfer && beat_q == 2'd3;
        rword     = {shift_q, mem_rdata};
        state_d   = state_q;
        beat_d    = beat_q;
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        if (state_q == IDLE && (c_req || d_req)) begin
            state_d = XFER;
            beat_d  = 2'd0;
            grant_d = win;
            we_d    = win ? d_we : c_we;
            addr_d  = win ? d_addr : c_addr;
            wdata_d = win ? d_wdata : c_wdata;
        end
        if (xfer) begin
            beat_d  = beat_q + 2'd1;
            shift_d = rword[23:0];
            state_d = last ? DONE : XFER;
        end
        if (last && !we_q) begin
            c_rdata_d = grant_q ? c_rdata_q : rword;
            d_rdata_d = grant_q ? rword : d_rdata_q;
        end
        if (state_q[1])
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= 2'd0;
            grant_q   <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign mem_we    = xfer && we_q;
    assign mem_addr  = xfer ? addr_q + AW'(beat_q) : '0;
    assign mem_wdata = !mem_we         ? 8'h00 :
                       beat_q == 2'd0 ? wdata_q[31:24] :
                       beat_q == 2'd1 ? wdata_q[23:16] :
                       beat_q == 2'd2 ? wdata_q[15:8]  : wdata_q[7:0];
    assign c_ack     = state_q == DONE && !grant_q;
    assign d_ack     = state_q == DONE && grant_q;
    assign c_rdata   = c_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = state_q != IDLE;
    assign grant_id  = grant_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of the dmem port arbiter against a
// behavioural 32-byte memory.
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req, c_we, c_ack, d_req, d_we, d_ack;
    logic [4:0]  c_addr, d_addr, mem_addr;
    logic [31:0] c_wdata, c_rdata, d_wdata, d_rdata;
    logic        mem_we, busy, grant_id;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  mem [32];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [6:0]  bm, am, om;
    logic [31:0] rd;
    logic [17:0] cm, dm;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    dmem_port_arbiter #(.AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // one request from cycle 0; records busy/ack per cycle over cycles 0..6
    task automatic xfer(input logic p, input logic we, input logic [4:0] a, input logic [31:0] wd,
                        input int drop_k, output logic [6:0] b, output logic [6:0] ak,
                        output logic [6:0] ok, output logic [31:0] r);
        b = '0; ak = '0; ok = '0; r = '0;
        if (p) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
        else   begin c_req = 1; c_we = we; c_addr = a; c_wdata = wd; end
        for (int k = 0; k < 7; k++) begin
            if (k == drop_k) begin
                c_req = 0; d_req = 0;
                c_addr = ~c_addr; d_addr = ~d_addr; c_wdata = ~c_wdata; d_wdata = ~d_wdata;
                c_we = ~c_we; d_we = ~d_we;
            end
            b[k]  = busy;
            ak[k] = p ? d_ack : c_ack;
            ok[k] = p ? c_ack : d_ack;
            if (ak[k]) r = p ? d_rdata : c_rdata;
            tick;
            if (ak[k]) begin c_req = 0; d_req = 0; end
        end
    endtask

    initial begin
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        tick; tick;
        check("rst_busy", 32'(busy), 0);
        check("rst_acks", {30'd0, c_ack, d_ack}, 0);
        check("rst_grant", 32'(grant_id), 1);
        check("rst_mem_if", {18'd0, mem_we, mem_addr, mem_wdata}, 0);
        check("rst_rdata", c_rdata | d_rdata, 0);
        rst_n = 1;
        tick;

        xfer(0, 1, 5'd4, 32'hDEADBEEF, -1, bm, am, om, rd);
        check("wr_busy_cycles", 32'(bm), 32'b0111110);
        check("wr_c_ack_cycles", 32'(am), 32'b0100000);
        check("wr_d_ack_cycles", 32'(om), 0);
        check("wr_mem4", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);

        xfer(0, 0, 5'd4, 32'h0, -1, bm, am, om, rd);
        check("rd_c_ack_cycles", 32'(am), 32'b0100000);
        check("rd_c_rdata_at_ack", rd, 32'hDEADBEEF);
        check("rd_c_rdata_held", c_rdata, 32'hDEADBEEF);
        check("rd_d_rdata", d_rdata, 0);

        xfer(1, 1, 5'd30, 32'h11223344, -1, bm, am, om, rd);
        check("dwr_d_ack_cycles", 32'(am), 32'b0100000);
        check("dwr_c_ack_cycles", 32'(om), 0);
        check("dwr_wrap_mem", {mem[30], mem[31], mem[0], mem[1]}, 32'h11223344);
        check("dwr_grant", 32'(grant_id), 1);

        // both ports request continuously from reset release
        rst_n = 0;
        tick;
        c_we = 0; c_addr = 5'd4; d_we = 0; d_addr = 5'd30;
        c_req = 1; d_req = 1; rst_n = 1;
        cm = '0; dm = '0;
        for (int k = 0; k < 18; k++) begin
            cm[k] = c_ack;
            dm[k] = d_ack;
            tick;
        end
        c_req = 0; d_req = 0;
        check("rr_c_ack_cycles", 32'(cm), (32'd1 << 5) | (32'd1 << 17));
        check("rr_d_ack_cycles", 32'(dm), 32'd1 << 11);
        check("rr_c_rdata", c_rdata, 32'hDEADBEEF);
        check("rr_d_rdata", d_rdata, 32'h11223344);
        tick;

        c_req = 1; c_we = 1; c_addr = 5'd8; c_wdata = 32'hAABBCCDD;
        tick; tick; tick;
        check("abort_beat2_addr", {26'd0, mem_we, mem_addr}, {26'd0, 1'b1, 5'd10});
        rst_n = 0;
        #1;
        check("abort_mem_if", {18'd0, mem_we, mem_addr, mem_wdata}, 0);
        check("abort_busy_acks", {29'd0, busy, c_ack, d_ack}, 0);
        check("abort_grant", 32'(grant_id), 1);
        check("abort_rdata", c_rdata | d_rdata, 0);
        c_req = 0;
        tick; tick;
        check("abort_mem8", {mem[8], mem[9], mem[10], mem[11]}, 32'hAABB0000);
        rst_n = 1;
        tick;

        xfer(0, 1, 5'd12, 32'h01020304, 2, bm, am, om, rd);
        check("drop_c_ack_cycles", 32'(am), 32'b0100000);
        check("drop_busy_cycles", 32'(bm), 32'b0111110);
        check("drop_mem12", {mem[12], mem[13], mem[14], mem[15]}, 32'h01020304);
        check("drop_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
